// File: rtl/mlaccel_pkg.sv
// Shared types and widths for the mlaccel command path.
package mlaccel_pkg;

   localparam int CMD_W      = 32;
   localparam int AW_DEFAULT = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_WAIT,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/mlaccel_seq_fifo.sv
// Prefetch FIFO with a registered head: data written at cycle end is visible next cycle.
// A write is accepted while full only if a pop happens in the same cycle.
module mlaccel_seq_fifo
   import mlaccel_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [CMD_W-1:0]       wr_dat,
   input  logic                   rd_en,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [CMD_W-1:0]       head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [CMD_W-1:0] mem_q [DEPTH];
   logic [CMD_W-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    rd_nxt;
   logic [CW-1:0]    count_q, count_d;
   logic [CMD_W-1:0] head_q, head_d;
   logic             push, pop;

   assign empty  = (count_q == '0);
   assign full   = (count_q == CW'(DEPTH));
   assign pop    = rd_en && !empty;
   assign push   = wr_en && (!full || pop);
   assign rd_nxt = rd_ptr_q + 1'b1;
   assign count  = count_q;
   assign head   = head_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      head_d   = head_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = wr_dat;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_nxt;
      end
      // Head must already hold the next entry when it becomes visible, so it
      // bypasses the array when the incoming word is the only one left.
      if (empty) begin
         if (push) head_d = wr_dat;
      end else if (pop && count_q == CW'(1)) begin
         if (push) head_d = wr_dat;
      end else if (pop) begin
         head_d = mem_q[rd_nxt];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/mlaccel_sequencer.sv
// Fetches a command list from memory and streams it to the compute core, then signals done.
// First command appears 3 cycles after start; cmd_ready low stalls reads once the FIFO is reserved.
module mlaccel_sequencer
   import mlaccel_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = AW_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [AW-1:0]    start_addr,
   input  logic [15:0]      start_count,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [AW-1:0]    rd_addr,
   input  logic [CMD_W-1:0] rd_data,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [CMD_W-1:0] cmd_data,
   input  logic             compute_busy
);

   localparam int CW = $clog2(DEPTH) + 1;

   seq_state_t    state_q, state_d;
   logic          start_ready_q, start_ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          rd_en_q, rd_en_d;
   logic          wr_pend_q, wr_pend_d;
   logic          wait_first_q, wait_first_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   resv;
   logic          start_hs;

   assign start_hs    = start_valid && start_ready_q;
   assign start_ready = start_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign rd_en       = rd_en_q;
   assign rd_addr     = addr_q;
   assign cmd_valid   = !fifo_empty;

   mlaccel_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .wr_en  (wr_pend_q),
      .wr_dat (rd_data),
      .rd_en  (cmd_ready),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count),
      .head   (cmd_data)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      rd_en_d      = 1'b0;
      wr_pend_d    = rd_en_q;
      wait_first_d = wait_first_q;
      // Slots already owed: stored words, the word landing this cycle, the read issuing now.
      resv = (CW+1)'(fifo_count) + (CW+1)'(wr_pend_q) + (CW+1)'(rd_en_q);

      case (state_q)
         S_IDLE: begin
            if (start_hs) begin
               if (start_count != 16'd0) begin
                  rd_en_d = 1'b1;
                  addr_d  = start_addr;
                  cnt_d   = start_count - 16'd1;
                  state_d = (start_count == 16'd1) ? S_DRAIN : S_FETCH;
               end else begin
                  state_d      = S_WAIT;
                  wait_first_d = 1'b1;
               end
            end
         end
         S_FETCH: begin
            if (!fifo_full && resv < (CW+1)'(DEPTH)) begin
               rd_en_d = 1'b1;
               addr_d  = addr_q + 1'b1;
               cnt_d   = cnt_q - 16'd1;
               if (cnt_q == 16'd1) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (fifo_empty && !rd_en_q && !wr_pend_q) begin
               state_d      = S_WAIT;
               wait_first_d = 1'b1;
            end
         end
         S_WAIT: begin
            // The core's busy lags our last command by a cycle, so ignore it once.
            if (wait_first_q) begin
               wait_first_d = 1'b0;
            end else if (!compute_busy) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      start_ready_d = (state_d == S_IDLE);
      busy_d        = (state_d != S_IDLE);
      done_d        = (state_d == S_DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         start_ready_q <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         rd_en_q       <= 1'b0;
         wr_pend_q     <= 1'b0;
         wait_first_q  <= 1'b0;
         addr_q        <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         start_ready_q <= start_ready_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         rd_en_q       <= rd_en_d;
         wr_pend_q     <= wr_pend_d;
         wait_first_q  <= wait_first_d;
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mlaccel_sequencer.sv
// Bench for mlaccel_sequencer: directed timing cases plus a randomized stream scored
// against the expected command list computed from each job's address and count.
module tb_mlaccel_sequencer;

   localparam int DEPTH = 4;
   localparam int AW    = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start_valid = 1'b0;
   logic          start_ready;
   logic [AW-1:0] start_addr = '0;
   logic [15:0]   start_count = '0;
   logic          busy, done, rd_en;
   logic [AW-1:0] rd_addr;
   logic [31:0]   rd_data = 32'hDEAD_BEEF;
   logic          cmd_valid;
   logic          cmd_ready = 1'b0;
   logic [31:0]   cmd_data;
   logic          compute_busy = 1'b0;

   int total = 0;
   int bad   = 0;
   int n_pop = 0, n_done = 0, n_rd = 0, n_vld = 0;

   logic [31:0]   exp_q[$];
   logic [15:0]   rd_log[$];
   logic          pend_en = 1'b0;
   logic [15:0]   pend_addr = '0;
   logic          stall_prev = 1'b0;
   logic [31:0]   stall_dat = '0;

   mlaccel_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clock        (clock),
      .reset        (reset),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .start_addr   (start_addr),
      .start_count  (start_count),
      .busy         (busy),
      .done         (done),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_data     (cmd_data),
      .compute_busy (compute_busy)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return 32'hA000_0000 + {16'h0, a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Memory: data for a read issued in cycle c is presented throughout cycle c+1.
   always @(negedge clock) begin
      pend_en   = rd_en;
      pend_addr = rd_addr;
   end
   always @(posedge clock) begin
      #1;
      rd_data = pend_en ? mem_word(pend_addr) : 32'hDEAD_BEEF;
   end

   always @(negedge clock) begin
      if (!reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_vld", 32'(cmd_valid), 1);
            chk("hold_dat", cmd_data, stall_dat);
         end
         if (cmd_valid) n_vld++;
         if (cmd_valid && cmd_ready) begin
            chk("cmd_avail", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("cmd_order", cmd_data, exp_q.pop_front());
            n_pop++;
         end
         stall_prev = cmd_valid && !cmd_ready;
         stall_dat  = cmd_data;
         if (done) n_done++;
         if (rd_en) begin
            n_rd++;
            rd_log.push_back(rd_addr);
         end
      end
   end

   task automatic start_job(input logic [15:0] a, input logic [15:0] n);
      int k = 0;
      while (!start_ready && k < 100) begin
         step();
         k++;
      end
      chk("start_rdy", 32'(start_ready), 1);
      start_valid = 1'b1;
      start_addr  = a;
      start_count = n;
      for (int i = 0; i < int'(n); i++) exp_q.push_back(mem_word(16'(int'(a) + i)));
      step();
      start_valid = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input bit rnd, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (rnd) begin
            cmd_ready    = ($urandom_range(0, 3) != 0);
            compute_busy = ($urandom_range(0, 2) == 0);
         end
         step();
         if (done) seen = 1'b1;
      end
   endtask

   initial begin
      #800000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          seen;
      int          r0, p0, d0, v0, cmds;
      logic [15:0] a, n, ea;

      repeat (2) step();
      chk("rst_start_ready", 32'(start_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_rd_addr", 32'(rd_addr), 0);
      chk("rst_cmd_valid", 32'(cmd_valid), 0);
      chk("rst_cmd_data", cmd_data, 0);
      reset = 1'b1;
      step();

      // Basic job: exact first-command latency and one-per-cycle delivery.
      cmd_ready = 1'b1;
      compute_busy = 1'b0;
      start_job(16'h0010, 16'd3);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_start_ready", 32'(start_ready), 0);
      chk("t1_rd_en", 32'(rd_en), 1);
      chk("t1_rd_addr", 32'(rd_addr), 32'h10);
      step();
      chk("t1_rd_addr2", 32'(rd_addr), 32'h11);
      chk("t1_no_vld_t2", 32'(cmd_valid), 0);
      step();
      compute_busy = 1'b1;
      chk("t1_vld_t3", 32'(cmd_valid), 1);
      chk("t1_dat_t3", cmd_data, 32'hA000_0010);
      step();
      chk("t1_dat_t4", cmd_data, 32'hA000_0011);
      step();
      compute_busy = 1'b0;
      chk("t1_dat_t5", cmd_data, 32'hA000_0012);
      d0 = n_done;
      run_until_done(40, 1'b0, seen);
      chk("t1_done_seen", 32'(seen), 1);
      step();
      chk("t1_busy_low", 32'(busy), 0);
      chk("t1_done_low", 32'(done), 0);
      repeat (3) step();
      chk("t1_done_once", n_done - d0, 1);
      chk("t1_drained", exp_q.size(), 0);

      // Zero-length job: no reads, done exactly at T+3.
      r0 = n_rd;
      start_job(16'h0050, 16'd0);
      chk("t2_busy", 32'(busy), 1);
      chk("t2_rd_en", 32'(rd_en), 0);
      step();
      chk("t2_done_t2", 32'(done), 0);
      step();
      chk("t2_done_t3", 32'(done), 1);
      step();
      chk("t2_done_t4", 32'(done), 0);
      chk("t2_busy_t4", 32'(busy), 0);
      chk("t2_start_ready", 32'(start_ready), 1);
      chk("t2_no_reads", n_rd - r0, 0);

      // Backpressure: only DEPTH reads before the stall, head held stable.
      cmd_ready = 1'b0;
      r0 = n_rd;
      p0 = n_pop;
      start_job(16'h0200, 16'd8);
      repeat (20) step();
      chk("t3_stall_reads", n_rd - r0, DEPTH);
      chk("t3_vld", 32'(cmd_valid), 1);
      chk("t3_head", cmd_data, 32'hA000_0200);
      cmd_ready = 1'b1;
      run_until_done(80, 1'b0, seen);
      chk("t3_done_seen", 32'(seen), 1);
      chk("t3_pops", n_pop - p0, 8);
      chk("t3_drained", exp_q.size(), 0);
      step();

      // Address wrap at the top of the space.
      rd_log.delete();
      start_job(16'hFFFE, 16'd4);
      run_until_done(60, 1'b0, seen);
      chk("t4_done_seen", 32'(seen), 1);
      chk("t4_reads", rd_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         ea = 16'hFFFE + 16'(i);
         chk("t4_rd_addr", (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hFFFF_FFFF, 32'(ea));
      end
      step();

      // Start requests while a job is running are refused and leave it intact.
      p0 = n_pop;
      start_job(16'h0300, 16'd6);
      start_valid = 1'b1;
      start_addr  = 16'h0999;
      start_count = 16'd5;
      for (int i = 0; i < 3; i++) begin
         chk("t5_start_ready", 32'(start_ready), 0);
         step();
      end
      start_valid = 1'b0;
      run_until_done(80, 1'b0, seen);
      chk("t5_done_seen", 32'(seen), 1);
      chk("t5_pops", n_pop - p0, 6);
      chk("t5_drained", exp_q.size(), 0);
      step();

      // Reset in the middle of a job, with a read still returning after release.
      d0 = n_done;
      start_job(16'h0400, 16'd6);
      step();
      step();
      reset = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_start_ready", 32'(start_ready), 1);
      chk("t6_rst_rd_en", 32'(rd_en), 0);
      chk("t6_rst_rd_addr", 32'(rd_addr), 0);
      chk("t6_rst_cmd_valid", 32'(cmd_valid), 0);
      chk("t6_rst_cmd_data", cmd_data, 0);
      exp_q.delete();
      #1;
      reset = 1'b1;
      v0 = n_vld;
      repeat (10) step();
      chk("t6_no_vld", n_vld - v0, 0);
      chk("t6_no_done", n_done - d0, 0);
      start_job(16'h0020, 16'd2);
      run_until_done(40, 1'b0, seen);
      chk("t6_restart_done", 32'(seen), 1);
      chk("t6_restart_drained", exp_q.size(), 0);
      step();

      // Randomized stream: random jobs, random ready and core busy.
      cmds = 0;
      while (cmds < 1000) begin
         a = 16'($urandom);
         n = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
         p0 = n_pop;
         start_job(a, n);
         run_until_done(int'(n) * 20 + 100, 1'b1, seen);
         compute_busy = 1'b0;
         cmd_ready    = 1'b1;
         chk("rnd_done_seen", 32'(seen), 1);
         chk("rnd_pops", n_pop - p0, 32'(n));
         chk("rnd_drained", exp_q.size(), 0);
         step();
         cmds += int'(n);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
